connect4_renderer: RTL and testbench

CONNECT4_RENDERER -- requirements
Module: connect4_renderer

---
 rtl/connect4_renderer.sv | 248 ++++++++++++++++++++++++
 tb/tb_connect4_renderer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_renderer.sv
// connect4_renderer: pixel renderer for a 7x6 Connect-4 board on a 640x480 VGA raster.
//
// Ports:
//   clk, reset          - pixel clock; asynchronous active-high reset
//   x_in, y_in          - current pixel column / line from the timing generator
//   video_on            - visible-area flag aligned with x_in/y_in
//   hsync_in, vsync_in  - sync pulses aligned with x_in/y_in
//   board               - 42 cells x 2 bits, cell i = row*7+col (00/11 empty, 01 P1, 10 P2)
//   win_mask            - bit i marks cell i as part of the winning line
//   cursor_col          - preview column 0..6, 7 = no preview
//   player              - current player (0 = P1, 1 = P2)
//   rgb                 - {R,G,B} 4 bits each, 3 clk after the pixel
//   hsync_out/vsync_out - sync pulses delayed 3 clk to match rgb
//   frame_start         - one-clk pulse when the shadow registers load
//
// Build option: define WIN_BLINK_EN to blink winning discs with a 64-frame period;
// otherwise winning discs are drawn steady white.
module connect4_renderer (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [83:0] board,
  input  logic [41:0] win_mask,
  input  logic [2:0]  cursor_col,
  input  logic        player,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  // Shadow copies: rendering only ever looks at these, so mid-frame input changes cannot tear.
  logic [83:0] board_sh_q;
  logic [41:0] win_sh_q;
  logic [2:0]  cur_sh_q;
  logic        player_sh_q;
  logic        edge_prev_q;
  logic        frame_start_q;
  logic        edge_now_s;
  logic        fs_d;
`ifdef WIN_BLINK_EN
  logic [5:0]  fcnt_q;
`endif

  // Frame edge: first clk on which the raster sits at (0,480).
  always_comb begin
    edge_now_s = (x_in == 10'd0) && (y_in == 10'd480);
    fs_d       = edge_now_s && !edge_prev_q;
  end

  // Edge history, frame_start pulse, shadow load and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_prev_q   <= 1'b0;
      frame_start_q <= 1'b0;
      board_sh_q    <= 84'd0;
      win_sh_q      <= 42'd0;
      cur_sh_q      <= 3'd0;
      player_sh_q   <= 1'b0;
`ifdef WIN_BLINK_EN
      fcnt_q        <= 6'd0;
`endif
    end else begin
      edge_prev_q   <= edge_now_s;
      frame_start_q <= fs_d;
      if (fs_d) begin
        board_sh_q  <= board;
        win_sh_q    <= win_mask;
        cur_sh_q    <= cursor_col;
        player_sh_q <= player;
`ifdef WIN_BLINK_EN
        fcnt_q      <= fcnt_q + 6'd1;
`endif
      end
    end
  end

  // ---------------- Stage 1: region decode and disc-centre offsets ----------------
  logic [9:0]        xo_s, yo_s;
  logic              in_x_s, in_board_d, in_strip_d;
  logic [2:0]        col_d, row_d;
  logic signed [6:0] dx_d, dy_d;
  logic              von1_q, board1_q, strip1_q;
  logic [2:0]        col1_q, row1_q;
  logic signed [6:0] dx1_q, dy1_q;

  // Offsets wrap for pixels left of / above the board, so one unsigned compare covers both bounds.
  always_comb begin
    xo_s       = x_in - 10'd96;
    yo_s       = y_in - 10'd64;
    in_x_s     = (xo_s <= 10'd447);
    in_board_d = in_x_s && (yo_s <= 10'd383);
    in_strip_d = in_x_s && (y_in <= 10'd63);
    col_d      = xo_s[8:6];
    if (in_board_d) begin
      row_d = yo_s[8:6];
    end else begin
      row_d = 3'd0;
    end
    // yo_s[5:0] equals y_in[5:0], so the strip shares the board's dy formula.
    dx_d = $signed({1'b0, xo_s[5:0]}) - 7'sd32;
    dy_d = $signed({1'b0, yo_s[5:0]}) - 7'sd32;
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      von1_q   <= 1'b0;
      board1_q <= 1'b0;
      strip1_q <= 1'b0;
      col1_q   <= 3'd0;
      row1_q   <= 3'd0;
      dx1_q    <= 7'sd0;
      dy1_q    <= 7'sd0;
    end else begin
      von1_q   <= video_on;
      board1_q <= in_board_d;
      strip1_q <= in_strip_d;
      col1_q   <= col_d;
      row1_q   <= row_d;
      dx1_q    <= dx_d;
      dy1_q    <= dy_d;
    end
  end

  // ---------------- Stage 2: squared radius and cell lookup ----------------
  logic [5:0]         idx_s;
  logic signed [11:0] dxe_s, dye_s;
  logic [11:0]        sq_d;
  logic [1:0]         code_d;
  logic               win_d, prev_d;
  logic               von2_q, board2_q, strip2_q, win2_q, prev2_q, pl2_q;
  logic [11:0]        sq2_q;
  logic [1:0]         code2_q;
`ifdef WIN_BLINK_EN
  logic               blank2_q;
`endif

  // Sum kept 12 bits wide so the cell corner (-32,-32) reads 2048 rather than wrapping to 0.
  always_comb begin
    idx_s  = ({3'd0, row1_q} * 6'd7) + {3'd0, col1_q};
    dxe_s  = 12'(dx1_q);
    dye_s  = 12'(dy1_q);
    sq_d   = $unsigned(dxe_s * dxe_s) + $unsigned(dye_s * dye_s);
    code_d = 2'b00;
    win_d  = 1'b0;
    for (int i = 0; i < 42; i++) begin
      if (idx_s == 6'(i)) begin
        code_d = board_sh_q[2*i +: 2];
        win_d  = win_sh_q[i];
      end else begin
        code_d = code_d;
      end
    end
    // Cursor value 7 never matches a strip column (0..6), which suppresses the preview.
    prev_d = strip1_q && (col1_q == cur_sh_q);
  end

  // Stage 2 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      von2_q   <= 1'b0;
      board2_q <= 1'b0;
      strip2_q <= 1'b0;
      sq2_q    <= 12'd0;
      code2_q  <= 2'b00;
      win2_q   <= 1'b0;
      prev2_q  <= 1'b0;
      pl2_q    <= 1'b0;
`ifdef WIN_BLINK_EN
      blank2_q <= 1'b0;
`endif
    end else begin
      von2_q   <= von1_q;
      board2_q <= board1_q;
      strip2_q <= strip1_q;
      sq2_q    <= sq_d;
      code2_q  <= code_d;
      win2_q   <= win_d;
      prev2_q  <= prev_d;
      pl2_q    <= player_sh_q;
`ifdef WIN_BLINK_EN
      blank2_q <= fcnt_q[5];
`endif
    end
  end

  // ---------------- Stage 3: colour selection ----------------
  logic        disc_s;
  logic [11:0] base_s, rgb_d;
  logic [11:0] rgb_q;
  logic [2:0]  hs_q, vs_q;

  // Colour priority: blanking, board background, disc contents, preview, black.
  always_comb begin
    disc_s = (sq2_q <= 12'd676);
    case (code2_q)
      2'b01:   base_s = 12'hF00;
      2'b10:   base_s = 12'hFF0;
      default: base_s = 12'h000;
    endcase
    rgb_d = 12'h000;
    if (!von2_q) begin
      rgb_d = 12'h000;
    end else if (board2_q) begin
      if (!disc_s) begin
        rgb_d = 12'h00F;
      end else if (base_s == 12'h000) begin
        rgb_d = 12'h000;
      end else if (win2_q) begin
`ifdef WIN_BLINK_EN
        rgb_d = blank2_q ? 12'h000 : base_s;
`else
        rgb_d = 12'hFFF;
`endif
      end else begin
        rgb_d = base_s;
      end
    end else if (strip2_q && disc_s && prev2_q) begin
      rgb_d = pl2_q ? 12'hFF0 : 12'hF00;
    end else begin
      rgb_d = 12'h000;
    end
  end

  // Output colour register and 3-deep sync delay lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= 12'h000;
      hs_q  <= 3'd0;
      vs_q  <= 3'd0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= {hs_q[1:0], hsync_in};
      vs_q  <= {vs_q[1:0], vsync_in};
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hs_q[2];
  assign vsync_out   = vs_q[2];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_connect4_renderer.sv
// Scoreboard bench for connect4_renderer: stimulus pushes expected outputs computed by a
// geometric reference model; a negedge monitor pops and compares when each output is due.
module tb_connect4_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_in, y_in;
  logic        video_on, hsync_in, vsync_in;
  logic [83:0] board;
  logic [41:0] win_mask;
  logic [2:0]  cursor_col;
  logic        player;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_start;

  connect4_renderer dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .board(board), .win_mask(win_mask),
    .cursor_col(cursor_col), .player(player), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; } exp_t;
  typedef struct { int due; logic fs; } fs_t;
  exp_t q[$];
  fs_t  fq[$];

  // Reference model state: shadow copies and frame count as the spec describes them.
  logic [83:0] m_board = '0;
  logic [41:0] m_win = '0;
  int          m_cur = 0;
  bit          m_pl = 0;
  bit          m_prev = 0;
  int          m_fc = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] model_rgb(int x, int y, bit von);
    int c, r, dx, dy, i;
    logic [1:0] code;
    logic [11:0] base;
    if (!von) return 12'h000;
    if (x < 96 || x > 543 || y > 447) return 12'h000;
    c  = (x - 96) / 64;
    dx = (x - 96) % 64 - 32;
    if (y < 64) begin
      dy = y % 64 - 32;
      if (dx*dx + dy*dy <= 676 && c == m_cur) return m_pl ? 12'hFF0 : 12'hF00;
      return 12'h000;
    end
    r  = (y - 64) / 64;
    dy = (y - 64) % 64 - 32;
    if (dx*dx + dy*dy > 676) return 12'h00F;
    i = r*7 + c;
    code = m_board[2*i +: 2];
    if (code == 2'b01) base = 12'hF00;
    else if (code == 2'b10) base = 12'hFF0;
    else return 12'h000;
    if (m_win[i]) begin
`ifdef WIN_BLINK_EN
      return (m_fc >= 32) ? 12'h000 : base;
`else
      return 12'hFFF;
`endif
    end
    return base;
  endfunction

  task automatic drive(input int x, input int y, input bit von, input bit hs, input bit vs);
    exp_t e;
    fs_t  f;
    bit   edge_now, fs;
    @(posedge clk);
    #1;
    x_in = x[9:0]; y_in = y[9:0]; video_on = von; hsync_in = hs; vsync_in = vs;
    edge_now = (x == 0 && y == 480);
    fs = edge_now && !m_prev;
    m_prev = edge_now;
    if (fs) begin
      m_board = board; m_win = win_mask; m_cur = int'(cursor_col); m_pl = player;
      m_fc = (m_fc + 1) % 64;
    end
    e.due = cyc + 3; e.rgb = model_rgb(x, y, von); e.hs = hs; e.vs = vs;
    q.push_back(e);
    f.due = cyc + 1; f.fs = fs;
    fq.push_back(f);
  endtask

  task automatic frame_edge(input bit twice);
    drive(0, 479, 0, 0, 0);
    drive(0, 480, 0, 0, 1);
    if (twice) drive(0, 480, 0, 0, 1);
    drive(0, 481, 0, 0, 0);
  endtask

  // Monitor: compares every output that is due on this cycle.
  always @(negedge clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("rgb_missed", 12'h001, 12'h000);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        check("rgb", rgb, q[0].rgb);
        check("hsync_out", {11'd0, hsync_out}, {11'd0, q[0].hs});
        check("vsync_out", {11'd0, vsync_out}, {11'd0, q[0].vs});
        void'(q.pop_front());
      end
      while (fq.size() > 0 && fq[0].due < cyc) begin
        check("fs_missed", 12'h001, 12'h000);
        void'(fq.pop_front());
      end
      if (fq.size() > 0 && fq[0].due == cyc) begin
        check("frame_start", {11'd0, frame_start}, {11'd0, fq[0].fs});
        void'(fq.pop_front());
      end
    end
  end

  initial begin
    int x, y;
    reset = 1'b1;
    x_in = 10'd128; y_in = 10'd96; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    board = 84'd1; win_mask = 42'd0; cursor_col = 3'd7; player = 1'b0;
    // Outputs forced low while reset is held, even with active inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_rgb", rgb, 12'h000);
      check("reset_hs", {11'd0, hsync_out}, 12'h000);
      check("reset_vs", {11'd0, vsync_out}, 12'h000);
      check("reset_fs", {11'd0, frame_start}, 12'h000);
    end
    @(posedge clk); #1; reset = 1'b0;

    // Shadows are still clear: cell 0 renders empty until a frame edge.
    drive(128, 96, 1, 0, 0);
    drive(128, 96, 1, 0, 0);
    frame_edge(0);
    drive(128, 96, 1, 0, 0);   // F00
    drive(98, 66, 1, 0, 0);    // 00F
    drive(96, 64, 1, 0, 0);    // cell corner, outside disc

    // Board edges.
    board = 84'd0;
    frame_edge(1);
    drive(95, 100, 1, 0, 0);
    drive(96, 100, 1, 0, 0);
    drive(543, 100, 1, 0, 0);
    drive(544, 100, 1, 0, 0);
    drive(300, 63, 1, 0, 0);
    drive(300, 447, 1, 0, 0);
    drive(300, 448, 1, 0, 0);

    // Mid-frame board change must wait for the next frame edge.
    drive(512, 200, 1, 0, 0);
    board = 84'd0; board[83:82] = 2'b10;
    drive(512, 416, 1, 0, 0);
    drive(512, 416, 1, 0, 0);
    frame_edge(0);
    drive(512, 416, 1, 0, 0);

    // Preview strip.
    cursor_col = 3'd3; player = 1'b1;
    frame_edge(0);
    drive(320, 32, 1, 0, 0);
    drive(256, 32, 1, 0, 0);
    cursor_col = 3'd7;
    frame_edge(0);
    drive(320, 32, 1, 0, 0);

    // Sync pulses: 96 clk hsync, then vsync.
    for (int i = 0; i < 96; i++) drive($urandom_range(0, 639), $urandom_range(0, 479), 1, 1, 0);
    for (int i = 0; i < 10; i++) drive($urandom_range(0, 639), $urandom_range(0, 479), 1, 0, 0);
    for (int i = 0; i < 50; i++) drive($urandom_range(0, 639), $urandom_range(0, 479), 1, 0, 1);
    for (int i = 0; i < 10; i++) drive($urandom_range(0, 639), $urandom_range(0, 479), 1, 0, 0);

    // Winning disc across more than a full 64-frame blink period.
    board = 84'd1; win_mask = 42'd1;
    for (int f = 0; f < 68; f++) begin
      frame_edge(0);
      drive(128, 96, 1, 0, 0);
    end

    // Randomised pixels, inputs and frame edges.
    for (int i = 0; i < 2500; i++) begin
      if (i % 60 == 0) begin
        board      = {$urandom, $urandom, $urandom};
        win_mask   = {$urandom & $urandom, $urandom & $urandom};
        cursor_col = 3'($urandom_range(0, 7));
        player     = 1'($urandom);
      end
      if (i % 250 == 0) frame_edge(1'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        x = $urandom_range(90, 550); y = $urandom_range(0, 455);
      end else begin
        x = $urandom_range(0, 799); y = $urandom_range(0, 524);
      end
      if (x == 0 && y == 480) y = 481;
      drive(x, y, 1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom));
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && (q.size() > 0 || fq.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    if (q.size() > 0 || fq.size() > 0) check("drain", 12'(q.size() + fq.size()), 12'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
